// File: rtl/trig_pkg.sv
// Shared types and constants for the sine/cosine angle sequencer.
// Sequencer FSM states, angle constants and LUT operation encodings.
package trig_pkg;

    typedef enum logic [2:0] {
        IDLE,
        NORM,
        FETCH_SIN,
        FETCH_COS,
        DONE
    } trig_seq_state_t;

    localparam int ANGLE_FULL    = 360;
    localparam int ANGLE_HALF    = 180;
    localparam int ANGLE_QUARTER = 90;

    localparam logic LUT_OP_SIN = 1'b0;
    localparam logic LUT_OP_COS = 1'b1;

endpackage

// File: rtl/trig_angle_norm.sv
// Iterative angle normalizer: folds a signed angle into [0,360] one +/-360 step per cycle.
// Flags an error when MAX_NORM_ITERS corrections still leave the angle out of range.
module trig_angle_norm
    import trig_pkg::*;
#(
    parameter int MAX_NORM_ITERS = 16,
    parameter int DATA_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] angle_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] angle
);

    localparam int CNT_W = $clog2(MAX_NORM_ITERS + 1);
    localparam logic signed [DATA_W-1:0] FULL = DATA_W'(ANGLE_FULL);

    logic signed [DATA_W-1:0] a_q;
    logic signed [DATA_W-1:0] a_step;
    logic [CNT_W-1:0]         cnt_q;
    logic                     in_range;
    logic                     step_in_range;
    logic                     last_step;

    // NOTE: every combinational output gets a default at the top of the block,
    // so no path through it can leave a value unassigned and infer a latch.
    always_comb begin
        in_range      = !a_q[DATA_W-1] && (a_q <= FULL);
        a_step        = a_q[DATA_W-1] ? (a_q + FULL) : (a_q - FULL);
        step_in_range = !a_step[DATA_W-1] && (a_step <= FULL);
        last_step     = (cnt_q == CNT_W'(MAX_NORM_ITERS - 1));
        // The final permitted correction is judged on its own result, so the
        // error is reported on the same cycle as the MAX_NORM_ITERS-th step.
        err           = busy && !in_range && last_step && !step_in_range;
        done          = busy && (in_range || err);
    end

    assign angle = a_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            cnt_q <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            a_q   <= angle_in;
            cnt_q <= '0;
            busy  <= 1'b1;
        end else if (busy) begin
            if (done) begin
                busy <= 1'b0;
            end else begin
                a_q   <= a_step;
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/trig_angle_sequencer.sv
// Angle sequencer around a combinational sine/cosine LUT: normalize, fetch sin then cos, return pair.
// Optional one-entry result cache enabled by defining TRIG_SEQ_CACHE_EN.
module trig_angle_sequencer
    import trig_pkg::*;
#(
    parameter int MAX_NORM_ITERS = 16,
    parameter int DATA_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_angle,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sin,
    output logic [DATA_W-1:0] out_cos,
    output logic [DATA_W-1:0] out_angle,
    output logic              out_err,
    output logic              lut_op_selector,
    output logic [DATA_W-1:0] lut_angle,
    input  logic [DATA_W-1:0] lut_value
);

    trig_seq_state_t   state_q;
    trig_seq_state_t   state_d;

    logic              norm_start;
    logic              norm_busy;
    logic              norm_done;
    logic              norm_err;
    logic [DATA_W-1:0] norm_angle;
    logic              norm_exit;

    logic              cache_hit;
    logic [DATA_W-1:0] hit_sin;
    logic [DATA_W-1:0] hit_cos;

    trig_angle_norm #(
        .MAX_NORM_ITERS (MAX_NORM_ITERS),
        .DATA_W         (DATA_W)
    ) u_norm (
        .clk      (clk),
        .rst      (rst),
        .start    (norm_start),
        .angle_in (req_angle),
        .busy     (norm_busy),
        .done     (norm_done),
        .err      (norm_err),
        .angle    (norm_angle)
    );

    assign norm_exit = (state_q == NORM) && norm_busy && norm_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        req_ready       = 1'b0;
        out_valid       = 1'b0;
        norm_start      = 1'b0;
        lut_op_selector = LUT_OP_SIN;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    norm_start = 1'b1;
                    state_d    = NORM;
                end
            end
            NORM: begin
                if (norm_exit) begin
                    state_d = (norm_err || cache_hit) ? DONE : FETCH_SIN;
                end
            end
            FETCH_SIN: begin
                state_d = FETCH_COS;
            end
            FETCH_COS: begin
                lut_op_selector = LUT_OP_COS;
                state_d         = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Result and LUT-address registers; none of them move while in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_sin   <= '0;
            out_cos   <= '0;
            out_angle <= '0;
            out_err   <= 1'b0;
            lut_angle <= '0;
        end else begin
            case (state_q)
                NORM: begin
                    if (norm_exit) begin
                        out_angle <= norm_angle;
                        if (norm_err) begin
                            out_err <= 1'b1;
                            out_sin <= '0;
                            out_cos <= '0;
                        end else begin
                            out_err <= 1'b0;
                            if (cache_hit) begin
                                out_sin <= hit_sin;
                                out_cos <= hit_cos;
                            end else begin
                                lut_angle <= norm_angle;
                            end
                        end
                    end
                end
                FETCH_SIN: begin
                    out_sin <= lut_value;
                end
                FETCH_COS: begin
                    out_cos <= lut_value;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef TRIG_SEQ_CACHE_EN
    logic              cache_valid;
    logic [DATA_W-1:0] cache_angle;
    logic [DATA_W-1:0] cache_sin;
    logic [DATA_W-1:0] cache_cos;

    // NOTE: only the valid bit is reset; the payload is never read while
    // cache_valid is low, so clearing it would add reset fan-out for nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            cache_valid <= 1'b0;
        end else if (norm_exit && norm_err) begin
            cache_valid <= 1'b0;
        end else if (state_q == FETCH_COS) begin
            cache_valid <= 1'b1;
            cache_angle <= lut_angle;
            cache_sin   <= out_sin;
            cache_cos   <= lut_value;
        end
    end

    assign cache_hit = cache_valid && (cache_angle == norm_angle);
    assign hit_sin   = cache_sin;
    assign hit_cos   = cache_cos;
`else
    assign cache_hit = 1'b0;
    assign hit_sin   = '0;
    assign hit_cos   = '0;
`endif

endmodule

// File: tb/tb_trig_angle_sequencer.sv
// Self-checking bench for trig_angle_sequencer with a behavioural LUT and scoreboard.
// Expected results come from an independent normalizer/cache model (TRIG_SEQ_CACHE_EN aware).
module tb_trig_angle_sequencer;

    localparam int MAX = 16;
    localparam int W   = 32;
    localparam int TIMEOUT = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_angle;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sin;
    logic [W-1:0] out_cos;
    logic [W-1:0] out_angle;
    logic         out_err;
    logic         lut_op_selector;
    logic [W-1:0] lut_angle;
    logic [W-1:0] lut_value;

    typedef struct {
        logic [W-1:0] angle;
        logic [W-1:0] sin_v;
        logic [W-1:0] cos_v;
        logic         err;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    int           total = 0;
    int           bad   = 0;
    logic         mdl_cache_valid = 1'b0;
    logic [W-1:0] mdl_cache_angle = '0;
    logic         op_log [0:TIMEOUT];
    logic [W-1:0] ang_log[0:TIMEOUT];

    always #5 clk = ~clk;

    function automatic logic [W-1:0] lut_fn(input logic op, input logic [W-1:0] a);
        return op ? (32'h0C05_0000 ^ (a * 32'd13)) : (32'h0051_0000 + a * 32'd7);
    endfunction

    assign lut_value = lut_fn(lut_op_selector, lut_angle);

    trig_angle_sequencer #(.MAX_NORM_ITERS(MAX), .DATA_W(W)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_angle       (req_angle),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_sin         (out_sin),
        .out_cos         (out_cos),
        .out_angle       (out_angle),
        .out_err         (out_err),
        .lut_op_selector (lut_op_selector),
        .lut_angle       (lut_angle),
        .lut_value       (lut_value)
    );

    function automatic exp_t model(input int angle);
        exp_t e;
        int   a = angle;
        int   k = 0;
        e.err = 1'b0;
        while (!(a >= 0 && a <= 360)) begin
            if (k == MAX) begin
                e.err = 1'b1;
                break;
            end
            a = (a < 0) ? a + 360 : a - 360;
            k++;
        end
        e.angle = a;
        if (e.err) begin
            e.sin_v = '0;
            e.cos_v = '0;
            e.lat   = MAX;
            mdl_cache_valid = 1'b0;
        end else begin
            e.sin_v = lut_fn(1'b0, a);
            e.cos_v = lut_fn(1'b1, a);
`ifdef TRIG_SEQ_CACHE_EN
            if (mdl_cache_valid && mdl_cache_angle == a) begin
                e.lat = 1 + k;
            end else begin
                e.lat = 3 + k;
                mdl_cache_valid = 1'b1;
                mdl_cache_angle = a;
            end
`else
            e.lat = 3 + k;
`endif
        end
        return e;
    endfunction

    // Drive one request, push its expectation, and wait (bounded) for out_valid.
    task automatic start_req(input int angle, output int lat);
        req_angle = angle;
        req_valid = 1'b1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL req_ready_idle: got %b expected 1 (angle %0d)", req_ready, angle);
        end
        sb.push_back(model(angle));
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < TIMEOUT) begin
            op_log[lat]  = lut_op_selector;
            ang_log[lat] = lut_angle;
            @(posedge clk); #1;
            lat++;
        end
        if (out_valid !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL out_valid_timeout: no result after %0d edges (angle %0d)", lat, angle);
        end
    endtask

    task automatic check_result(input int lat, output exp_t e);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty: got result with no expectation");
            e = '{default: '0};
            return;
        end
        e = sb.pop_front();
        total += 4;
        if (out_sin !== e.sin_v) begin
            bad++;
            $display("FAIL out_sin: got %h expected %h", out_sin, e.sin_v);
        end
        if (out_cos !== e.cos_v) begin
            bad++;
            $display("FAIL out_cos: got %h expected %h", out_cos, e.cos_v);
        end
        if (out_err !== e.err) begin
            bad++;
            $display("FAIL out_err: got %b expected %b", out_err, e.err);
        end
        if (lat != e.lat) begin
            bad++;
            $display("FAIL latency: got %0d expected %0d", lat, e.lat);
        end
        if (!e.err) begin
            total++;
            if (out_angle !== e.angle) begin
                bad++;
                $display("FAIL out_angle: got %0d expected %0d", out_angle, e.angle);
            end
        end
    endtask

    // Consume the result (out_ready already high) and check the return to IDLE.
    task automatic finish_req();
        @(posedge clk); #1;
        total += 2;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL out_valid_drop: got %b expected 0", out_valid);
        end
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL req_ready_after: got %b expected 1", req_ready);
        end
    endtask

    task automatic run_one(input int angle);
        int   lat;
        exp_t e;
        start_req(angle, lat);
        check_result(lat, e);
        finish_req();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total += 8;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready: got %b expected 1", req_ready); end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        if (out_err !== 1'b0) begin bad++; $display("FAIL rst_out_err: got %b expected 0", out_err); end
        if (out_sin !== '0) begin bad++; $display("FAIL rst_out_sin: got %h expected 0", out_sin); end
        if (out_cos !== '0) begin bad++; $display("FAIL rst_out_cos: got %h expected 0", out_cos); end
        if (out_angle !== '0) begin bad++; $display("FAIL rst_out_angle: got %h expected 0", out_angle); end
        if (lut_op_selector !== 1'b0) begin bad++; $display("FAIL rst_lut_op: got %b expected 0", lut_op_selector); end
        if (lut_angle !== '0) begin bad++; $display("FAIL rst_lut_angle: got %h expected 0", lut_angle); end
        rst = 1'b0;
        mdl_cache_valid = 1'b0;
    endtask

    task automatic test_basic();
        int   lat;
        exp_t e;
        start_req(30, lat);
        total += 5;
        if (op_log[0] !== 1'b0) begin bad++; $display("FAIL op_norm: got %b expected 0", op_log[0]); end
        if (op_log[1] !== 1'b0) begin bad++; $display("FAIL op_sin: got %b expected 0", op_log[1]); end
        if (op_log[2] !== 1'b1) begin bad++; $display("FAIL op_cos: got %b expected 1", op_log[2]); end
        if (ang_log[1] !== 32'd30) begin bad++; $display("FAIL lut_angle_sin: got %0d expected 30", ang_log[1]); end
        if (ang_log[2] !== 32'd30) begin bad++; $display("FAIL lut_angle_cos: got %0d expected 30", ang_log[2]); end
        check_result(lat, e);
        total++;
        if (lut_op_selector !== 1'b0) begin bad++; $display("FAIL op_done: got %b expected 0", lut_op_selector); end
        finish_req();
    endtask

    task automatic test_boundaries();
        int angles[6] = '{-390, 0, 360, -360, 361, -1};
        foreach (angles[i]) run_one(angles[i]);
    endtask

    task automatic test_error();
        run_one(360 * 20);
        run_one(-360 * 20);
        run_one(360 * 16 + 5);
    endtask

    task automatic test_hold();
        int   lat;
        exp_t e;
        out_ready = 1'b0;
        start_req(123, lat);
        check_result(lat, e);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            total += 4;
            if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_valid[%0d]: got %b expected 1", i, out_valid); end
            if (out_sin !== e.sin_v) begin bad++; $display("FAIL hold_sin[%0d]: got %h expected %h", i, out_sin, e.sin_v); end
            if (out_cos !== e.cos_v) begin bad++; $display("FAIL hold_cos[%0d]: got %h expected %h", i, out_cos, e.cos_v); end
            if (req_ready !== 1'b0) begin bad++; $display("FAIL hold_ready[%0d]: got %b expected 0", i, req_ready); end
        end
        out_ready = 1'b1;
        finish_req();
    endtask

    task automatic test_reset_midop();
        req_angle = 200;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mdl_cache_valid = 1'b0;
        total += 3;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_valid: got %b expected 0", out_valid); end
        if (req_ready !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b expected 1", req_ready); end
        if (lut_op_selector !== 1'b0) begin bad++; $display("FAIL abort_op: got %b expected 0", lut_op_selector); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_no_result[%0d]: got %b expected 0", i, out_valid); end
        end
        run_one(90);
    endtask

    task automatic test_cache();
        run_one(45);
        run_one(45);
        run_one(405);
        run_one(360 * 20);
        run_one(45);
    endtask

    task automatic test_back_to_back();
        int angles[5] = '{-30, 1000, 270, 270, -725};
        foreach (angles[i]) run_one(angles[i]);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_angle = '0;
        out_ready = 1'b1;
        test_reset();
        test_basic();
        test_boundaries();
        test_error();
        test_hold();
        test_reset_midop();
        test_cache();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
